// File: rtl/ccff_loader_pkg.sv
// Shared state encoding and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_WAIT_WORD = 3'd1;
   localparam state_t ST_SHIFT     = 3'd2;
   localparam state_t ST_RD_OUT    = 3'd3;
   localparam state_t ST_DONE      = 3'd4;

   function automatic int calc_nwords(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   function automatic int calc_last_bits(input int chain_len, input int word_w);
      return chain_len - (calc_nwords(chain_len, word_w) - 1) * word_w;
   endfunction

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ccff_bit_serdes.sv
// Per-word serialiser/deserialiser: shifts txreg out LSB-first on head while
// capturing tail bits into rxreg at the same bit index.
module ccff_bit_serdes
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = 8,
   localparam int CNT_W = cnt_w(WORD_W),
   localparam int NB_W  = cnt_w(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   input  logic [NB_W-1:0]   nbits,
   input  logic              tail,
   output logic              head,
   output logic              last_bit,
   output logic [WORD_W-1:0] rx_word
);

   logic [WORD_W-1:0] txreg_q, txreg_d;
   logic [WORD_W-1:0] rxreg_q, rxreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [NB_W-1:0]   nbits_q, nbits_d;
   logic              head_q, head_d;

   always_comb begin
      txreg_d   = txreg_q;
      rxreg_d   = rxreg_q;
      bit_cnt_d = bit_cnt_q;
      nbits_d   = nbits_q;
      head_d    = head_q;
      if (load) begin
         txreg_d   = data;
         rxreg_d   = '0;
         bit_cnt_d = '0;
         nbits_d   = nbits;
      end else if (shift) begin
         txreg_d            = txreg_q >> 1;
         rxreg_d[bit_cnt_q] = tail;
         bit_cnt_d          = bit_cnt_q + CNT_W'(1);
         head_d             = txreg_q[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txreg_q   <= '0;
         rxreg_q   <= '0;
         bit_cnt_q <= '0;
         nbits_q   <= '0;
         head_q    <= 1'b0;
      end else begin
         txreg_q   <= txreg_d;
         rxreg_q   <= rxreg_d;
         bit_cnt_q <= bit_cnt_d;
         nbits_q   <= nbits_d;
         head_q    <= head_d;
      end
   end

   // Outside shifting the head keeps presenting the last bit driven into the chain.
   assign head     = shift ? txreg_q[0] : head_q;
   assign last_bit = (NB_W'(bit_cnt_q) + NB_W'(1)) == nbits_q;
   assign rx_word  = rxreg_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain sequencer: streams NWORDS config words into the tile chain
// and returns the bits pushed out of ccff_tail as readback words.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   localparam int NWORDS    = calc_nwords(CHAIN_LEN, WORD_W);
   localparam int LAST_BITS = calc_last_bits(CHAIN_LEN, WORD_W);
   localparam int WI_W      = cnt_w(NWORDS + 1);
   localparam int NB_W      = cnt_w(WORD_W + 1);

   // Handshakes: a word moves on a prog_clk edge where valid and ready are both 1.
   // cfg_ready and rd_valid depend only on the registered state, never on the
   // partner's valid/ready, and the two are never high together.

   state_t            state_q, state_d;
   logic [WI_W-1:0]   word_idx_q, word_idx_d;
   logic              last_word;
   logic              load;
   logic              last_bit;
   logic [NB_W-1:0]   nbits;
   logic [WORD_W-1:0] rx_word;

   assign last_word = (word_idx_q == WI_W'(NWORDS - 1));
   assign nbits     = last_word ? NB_W'(LAST_BITS) : NB_W'(WORD_W);

   assign cfg_ready     = (state_q == ST_WAIT_WORD);
   assign ccff_shift_en = (state_q == ST_SHIFT);
   assign rd_valid      = (state_q == ST_RD_OUT);
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign rd_data       = rd_valid ? rx_word : '0;
   assign dbg_state     = state_q;
   assign load          = cfg_ready & cfg_valid;

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_WAIT_WORD;
               word_idx_d = '0;
            end
         end
         ST_WAIT_WORD: begin
            if (cfg_valid) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_bit) state_d = ST_RD_OUT;
         end
         ST_RD_OUT: begin
            if (rd_ready) begin
               word_idx_d = word_idx_q + WI_W'(1);
               state_d    = last_word ? ST_DONE : ST_WAIT_WORD;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state_q    <= ST_IDLE;
         word_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
      end
   end

   ccff_bit_serdes #(
      .WORD_W (WORD_W)
   ) u_serdes (
      .clk      (prog_clk),
      .rst_n    (pReset),
      .load     (load),
      .shift    (ccff_shift_en),
      .data     (cfg_data),
      .nbits    (nbits),
      .tail     (ccff_tail),
      .head     (ccff_head),
      .last_bit (last_bit),
      .rx_word  (rx_word)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: emulates a 20-bit tile chain and predicts head
// bits, readback words and chain image with a FIFO model of the chain.
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 20;
   localparam int WORD_W    = 8;
   localparam int NWORDS    = 3;
   localparam int LAST_BITS = 4;

   logic              prog_clk;
   logic              pReset;
   logic              start;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              busy;
   logic              done;
   logic [2:0]        dbg_state;

   ccff_chain_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W)
   ) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .start         (start),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .busy          (busy),
      .done          (done),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- tile chain emulator ----------------
   logic [CHAIN_LEN-1:0] tile_chain = '0;
   always @(posedge prog_clk)
      if (ccff_shift_en) tile_chain <= {tile_chain[CHAIN_LEN-2:0], ccff_head};
   assign ccff_tail = tile_chain[CHAIN_LEN-1];

   // ---------------- monitors ----------------
   int   cyc = 0;
   int   shift_cnt, cfg_hs, rd_hs, done_cnt, start_cyc, done_cyc;
   bit   overlap_seen;
   logic head_bits[$];
   logic [WORD_W-1:0] rd_words[$];

   always @(negedge prog_clk) begin
      cyc++;
      if (pReset) begin
         if (ccff_shift_en) begin
            shift_cnt++;
            head_bits.push_back(ccff_head);
         end
         if (cfg_valid && cfg_ready) cfg_hs++;
         if (rd_valid && rd_ready) begin
            rd_hs++;
            rd_words.push_back(rd_data);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (start && !busy) start_cyc = cyc;
         if (cfg_ready && rd_valid) overlap_seen = 1'b1;
      end
   end

   task automatic clear_mon();
      shift_cnt = 0; cfg_hs = 0; rd_hs = 0; done_cnt = 0;
      start_cyc = -1; done_cyc = -1; overlap_seen = 1'b0;
      head_bits.delete();
      rd_words.delete();
   endtask

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The chain is a FIFO of CHAIN_LEN bits: each shifted-in bit pushes the oldest one out.
   logic              model_fifo[$];
   logic [WORD_W-1:0] words [NWORDS];
   logic              exp_head[$];
   logic [WORD_W-1:0] exp_rd [NWORDS];

   task automatic model_load(input int nshift);
      int k;
      logic b, t;
      k = 0;
      exp_head.delete();
      for (int w = 0; w < NWORDS; w++) begin
         int nb;
         exp_rd[w] = '0;
         nb = (w == NWORDS - 1) ? LAST_BITS : WORD_W;
         for (int i = 0; i < nb; i++) begin
            if (k < nshift) begin
               b = words[w][i];
               exp_head.push_back(b);
               t = model_fifo.pop_front();
               model_fifo.push_back(b);
               exp_rd[w][i] = t;
               k++;
            end
         end
      end
   endtask

   function automatic logic [CHAIN_LEN-1:0] model_image();
      logic [CHAIN_LEN-1:0] img;
      for (int i = 0; i < CHAIN_LEN; i++) img[CHAIN_LEN-1-i] = model_fifo[i];
      return img;
   endfunction

   // ---------------- driver ----------------
   task automatic run_load(input int gap_mode, input int rd_stall, input bit busy_start,
                           input int abort_after, output bit finished);
      int wi, rd_n, stall_n, my_shifts;
      bit pulsed;
      wi = 0; rd_n = 0; stall_n = 0; my_shifts = 0; pulsed = 0; finished = 0;
      clear_mon();
      start = 1'b1; cfg_valid = 1'b0; rd_ready = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (c > 0) begin
            start = busy_start && (wi == 1) && !pulsed;
            if (start) pulsed = 1'b1;
         end
         cfg_valid = (wi < NWORDS) &&
                     (gap_mode == 0 || (gap_mode == 1 && c % 3 == 0) ||
                      (gap_mode == 2 && $urandom_range(0, 1) == 1));
         cfg_data  = cfg_valid ? words[wi] : WORD_W'($urandom);
         rd_ready  = !(rd_n == 0 && stall_n < rd_stall);
         @(negedge prog_clk);
         if (cfg_valid && cfg_ready) wi++;
         if (rd_valid && rd_ready) rd_n++;
         if (rd_valid && !rd_ready) begin
            stall_n++;
            chk("stall_rd_data", rd_data, exp_rd[0]);
            chk("stall_shift_en", ccff_shift_en, 1'b0);
            chk("stall_cfg_ready", cfg_ready, 1'b0);
            chk("stall_head_hold", ccff_head, words[0][WORD_W-1]);
         end
         if (ccff_shift_en) my_shifts++;
         if (done || (abort_after > 0 && my_shifts == abort_after)) begin
            finished = 1'b1;
            break;
         end
         @(posedge prog_clk); #1;
      end
      @(posedge prog_clk); #1;
      start = 1'b0; cfg_valid = 1'b0; rd_ready = 1'b0;
      if (rd_stall > 0 && abort_after == 0) chk("stall_cycles", stall_n, rd_stall);
   endtask

   task automatic check_load(input string tag, input int exp_lat);
      logic [CHAIN_LEN-1:0] obs_h, exp_h;
      chk($sformatf("%s_shift_cycles", tag), shift_cnt, CHAIN_LEN);
      chk($sformatf("%s_cfg_handshakes", tag), cfg_hs, NWORDS);
      chk($sformatf("%s_rd_handshakes", tag), rd_hs, NWORDS);
      chk($sformatf("%s_done_pulses", tag), done_cnt, 1);
      for (int i = 0; i < CHAIN_LEN; i++) begin
         obs_h[i] = (i < head_bits.size()) ? head_bits[i] : 1'bx;
         exp_h[i] = exp_head[i];
      end
      chk($sformatf("%s_head_seq", tag), obs_h, exp_h);
      for (int w = 0; w < NWORDS; w++)
         chk($sformatf("%s_rd_word%0d", tag, w),
             (w < rd_words.size()) ? rd_words[w] : 'x, exp_rd[w]);
      chk($sformatf("%s_chain_image", tag), tile_chain, model_image());
      chk($sformatf("%s_ready_valid_overlap", tag), overlap_seen, 1'b0);
      if (exp_lat > 0)
         chk($sformatf("%s_latency", tag), done_cyc - start_cyc + 1, exp_lat);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit fin;
      logic [CHAIN_LEN-1:0] img1;
      for (int i = 0; i < CHAIN_LEN; i++) model_fifo.push_back(1'b0);
      pReset = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; rd_ready = 1'b0;
      clear_mon();
      repeat (3) @(posedge prog_clk);
      #1;
      chk("reset_outputs",
          {cfg_ready, ccff_head, ccff_shift_en, rd_data, rd_valid, busy, done}, '0);
      chk("reset_state", dbg_state, 3'd0);
      pReset = 1'b1;
      @(posedge prog_clk); #1;

      // Directed load with the reference words; unstalled, so minimum latency.
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
      model_load(CHAIN_LEN);
      run_load(0, 0, 1'b0, 0, fin);
      chk("L1_finished", fin, 1'b1);
      check_load("L1", 1 + (WORD_W + 2) * (NWORDS - 1) + (LAST_BITS + 2) + 1);
      img1 = tile_chain;

      // Zero load reads back the previous image, with readback backpressure.
      words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
      model_load(CHAIN_LEN);
      run_load(0, 5, 1'b0, 0, fin);
      chk("L2_finished", fin, 1'b1);
      check_load("L2", 0);
      chk("L2_rd0_const", rd_words.size() > 0 ? rd_words[0] : 'x, 8'hA5);
      chk("L2_rd1_const", rd_words.size() > 1 ? rd_words[1] : 'x, 8'h3C);
      chk("L2_rd2_const", rd_words.size() > 2 ? rd_words[2] : 'x, 8'h0F);
      chk("L2_chain_zero", tile_chain, '0);

      // Same words as L1 with cfg_valid present one cycle in three.
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
      model_load(CHAIN_LEN);
      run_load(1, 0, 1'b0, 0, fin);
      chk("L3_finished", fin, 1'b1);
      check_load("L3", 0);
      chk("L3_image_vs_L1", tile_chain, img1);

      // Reset after 10 shift cycles.
      for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
      run_load(0, 0, 1'b0, 10, fin);
      chk("L4_abort_reached", fin, 1'b1);
      model_load(10);
      chk("L4_pre_reset_shift", ccff_shift_en, 1'b1);
      #2 pReset = 1'b0;
      #1;
      chk("L4_async_reset_outputs",
          {cfg_ready, ccff_head, ccff_shift_en, rd_data, rd_valid, busy, done, dbg_state}, '0);
      repeat (2) @(posedge prog_clk);
      #1 pReset = 1'b1;
      @(posedge prog_clk); #1;

      // Full load after the abort, with a start pulse while busy.
      for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
      model_load(CHAIN_LEN);
      run_load(0, 0, 1'b1, 0, fin);
      chk("L5_finished", fin, 1'b1);
      check_load("L5", 0);
      repeat (3) begin
         @(negedge prog_clk);
         chk("L5_idle_after_done", {busy, cfg_ready}, 2'b00);
      end
      @(posedge prog_clk); #1;

      // Randomized words, random cfg gaps and random readback stalls.
      for (int n = 0; n < 4; n++) begin
         for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
         model_load(CHAIN_LEN);
         run_load(2, $urandom_range(0, 3), 1'b0, 0, fin);
         chk($sformatf("R%0d_finished", n), fin, 1'b1);
         check_load($sformatf("R%0d", n), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain sequencer for one frac_logic tile.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the tile's ccff_head, asserting a shift enable for exactly CHAIN_LEN bits.
- Collects the bits emerging on ccff_tail into readback words, so that software can verify the old configuration or loop it back.
- Sits between the bitstream fetch logic and the tile's configuration-chain input.

Parameters:
- CHAIN_LEN, 20, number of configuration flip-flops in the chain (16 LUT bits, 1 mode bit, 3 mux SRAM bits).
- WORD_W, 8, width of the configuration and readback words.
- Derived, not overridable: NWORDS = ceil(CHAIN_LEN/WORD_W); LAST_BITS = CHAIN_LEN - (NWORDS-1)*WORD_W.

Ports:
- prog_clk  in  1  configuration clock; the block and the chain both run on it.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- cfg_data  in  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts cfg_data this cycle.
- ccff_head  out  1  serial bit into the chain.
- ccff_shift_en  out  1  chain clock enable; the chain shifts on a prog_clk edge only while this is 1.
- ccff_tail  in  1  serial bit out of the chain.
- rd_data  out  WORD_W  readback word; bit 0 is the first bit captured.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- busy  out  1  a load is in progress (any state except IDLE).
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset values (pReset=0, applied asynchronously): every output 0, state IDLE, all counters 0. ccff_shift_en drops immediately.
- A reset mid-load leaves the chain contents undefined. No partial readback word is emitted.
- States: IDLE, WAIT_WORD, SHIFT, RD_OUT, DONE.
- IDLE: start=1 moves to WAIT_WORD and clears word_idx. start is ignored in every other state.
- WAIT_WORD:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: latch cfg_data into the shift register, set nbits (WORD_W, or LAST_BITS for the last word), clear bit_cnt, go to SHIFT.
  - cfg_ready is registered-state based, with no combinational path from cfg_valid.
- SHIFT, one bit per cycle:
  - ccff_shift_en=1 and ccff_head=txreg[0].
  - At the edge: txreg shifts right, and ccff_tail is captured into rxreg[bit_cnt].
  - When bit_cnt reaches nbits-1, go to RD_OUT.
  - ccff_head holds its last value whenever shift_en=0.
- RD_OUT:
  - rd_valid=1 and rd_data=rxreg. Unused upper bits of the last word are 0.
  - On rd_ready, increment word_idx. If word_idx was NWORDS-1, go to DONE; otherwise go to WAIT_WORD.
  - rd_data is held stable while rd_valid=1 and rd_ready=0. No shifting occurs while waiting.
- DONE: done=1 for one cycle, then IDLE.
- Totals per load:
  - Exactly CHAIN_LEN cycles with ccff_shift_en=1.
  - Exactly NWORDS cfg handshakes and NWORDS rd handshakes.
- Latency: minimum 1 + (WORD_W+2)*(NWORDS-1) + (LAST_BITS+2) + 1 cycles, from start to done, when handshakes are never stalled.
- Counters:
  - bit_cnt is clog2(WORD_W) wide.
  - word_idx is clog2(NWORDS+1) wide and never wraps within a load.
- The block never asserts cfg_ready and rd_valid in the same cycle.
- Gaps on cfg_valid or rd_ready only stretch the load; they never change bit ordering.

Decomposition:
- Package ccff_loader_pkg:
  - state enum (IDLE, WAIT_WORD, SHIFT, RD_OUT, DONE);
  - helper functions for NWORDS, LAST_BITS and counter widths.
- Sub-module ccff_bit_serdes:
  - contains txreg, rxreg and bit_cnt;
  - inputs: load, shift and nbits;
  - outputs: head, last_bit and rx_word.
- The top level holds the FSM, the word counter and the handshakes.

Test Plan:
- Load and bit order (CHAIN_LEN=20, WORD_W=8): start, send 0xA5, 0x3C, 0x0F.
  - Exactly 20 shift_en cycles.
  - ccff_head sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1.
  - A 20-bit reference chain model holds the expected image; done pulses once.
- Readback: second load with 0x00, 0x00, 0x00.
  - rd words are 0xA5, 0x3C, 0x0F (last word: 4 bits, upper nibble 0).
  - Chain model is all zeros.
- Backpressure: hold rd_ready=0 for 5 cycles at the first RD_OUT.
  - shift_en stays 0, rd_data stays stable at 0xA5, cfg_ready stays 0.
  - Load then completes with correct data.
- Input gaps: cfg_valid toggled 1-of-3 cycles.
  - Still exactly 20 shift cycles; chain image identical to the unstalled case.
- Reset and start handling:
  - Assert pReset=0 after 10 shift cycles: all outputs 0 at once.
  - New start then performs a full 20-bit load.
  - A start pulse while busy has no effect (cfg handshake count stays 3).
